// File: rtl/mpram_rdarb_sclk_4r1w.sv
// Single-port-read RAM shared by four requesters under round-robin arbitration.
// One write port; a granted read returns its data one cycle later on that requester's registered outputs.
module mpram_rdarb_sclk_4r1w #(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int CLEAR_ON_INIT = 1,
    parameter int ENABLE_BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  req2,
    input  logic                  req3,
    input  logic [ADDR_WIDTH-1:0] raddr0,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    input  logic [ADDR_WIDTH-1:0] raddr3,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  gnt2,
    output logic                  gnt3,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic                  rvalid2,
    output logic                  rvalid3,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic [DATA_WIDTH-1:0] rdata3,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [3:0]                 req_s;
    logic [3:0][ADDR_WIDTH-1:0] raddr_s;
    logic [3:0]                 gnt_s;
    logic [1:0]                 gnt_idx_s;
    logic                       gnt_any_s;
    logic [1:0]                 cand_s;
    logic                       hit_s;
    logic [1:0]                 ptr_r;
    logic [ADDR_WIDTH-1:0]      rd_addr_s;
    logic [DATA_WIDTH-1:0]      mem_word_s;
    logic [DATA_WIDTH-1:0]      rd_word_s;
    logic [3:0]                 rvalid_r;
    logic [DATA_WIDTH-1:0]      rdata_r [4];
    logic                       busy_r;

    assign req_s   = {req3, req2, req1, req0};
    assign raddr_s = {raddr3, raddr2, raddr1, raddr0};

    // Round-robin search starting at the pointer; nothing is granted while in reset.
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_idx_s = 2'd0;
        cand_s    = 2'd0;
        hit_s     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand_s    = ptr_r + 2'(i);
            hit_s     = !rst && !gnt_any_s && req_s[cand_s];
            gnt_idx_s = hit_s ? cand_s : gnt_idx_s;
            gnt_any_s = gnt_any_s | hit_s;
        end
    end

    // One-hot grant decode from the winning index.
    always_comb begin
        gnt_s            = 4'b0000;
        gnt_s[gnt_idx_s] = gnt_any_s;
    end

    assign {gnt3, gnt2, gnt1, gnt0} = gnt_s;
    assign rd_addr_s = raddr_s[gnt_idx_s];

    generate
        if (CLEAR_ON_INIT != 0) begin : g_mem_clr
            logic [DATA_WIDTH-1:0] mem_r [DEPTH] = '{default: '0};

            // Write port; storage is deliberately untouched by rst.
            always_ff @(posedge clk) begin
                if (we) begin
                    mem_r[waddr] <= wdata;
                end
            end
            assign mem_word_s = mem_r[rd_addr_s];
        end else begin : g_mem_raw
            logic [DATA_WIDTH-1:0] mem_r [DEPTH];

            // Write port; storage is deliberately untouched by rst.
            always_ff @(posedge clk) begin
                if (we) begin
                    mem_r[waddr] <= wdata;
                end
            end
            assign mem_word_s = mem_r[rd_addr_s];
        end
    endgenerate

    // Same-cycle write to the granted address forwards the new word when bypass is enabled.
    always_comb begin
        if ((ENABLE_BYPASS != 0) && we && (waddr == rd_addr_s)) begin
            rd_word_s = wdata;
        end else begin
            rd_word_s = mem_word_s;
        end
    end

    // Read data / valid registers, arbitration pointer and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r    <= 2'd0;
            rvalid_r <= 4'b0000;
            busy_r   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                rdata_r[k] <= '0;
            end
        end else begin
            busy_r   <= |(req_s & ~gnt_s);
            rvalid_r <= gnt_s;
            if (gnt_any_s) begin
                ptr_r <= gnt_idx_s + 2'd1;
            end
            for (int k = 0; k < 4; k++) begin
                if (gnt_s[k]) begin
                    rdata_r[k] <= rd_word_s;
                end
            end
        end
    end

    assign {rvalid3, rvalid2, rvalid1, rvalid0} = rvalid_r;
    assign rdata0 = rdata_r[0];
    assign rdata1 = rdata_r[1];
    assign rdata2 = rdata_r[2];
    assign rdata3 = rdata_r[3];
    assign busy   = busy_r;

endmodule

// File: tb/tb_mpram_rdarb_sclk_4r1w.sv
// Directed bench for the 4-reader arbitrated RAM: expected read results go through a scoreboard queue.
module tb_mpram_rdarb_sclk_4r1w;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  req;
    logic [4:0]  raddr [4];
    logic        gnt0, gnt1, gnt2, gnt3;
    logic        rvalid0, rvalid1, rvalid2, rvalid3;
    logic [31:0] rdata0, rdata1, rdata2, rdata3;
    logic        busy;

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mem_m [32];
    logic [31:0] exp_rdata [4];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    mpram_rdarb_sclk_4r1w dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .req0(req[0]), .req1(req[1]), .req2(req[2]), .req3(req[3]),
        .raddr0(raddr[0]), .raddr1(raddr[1]), .raddr2(raddr[2]), .raddr3(raddr[3]),
        .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2), .gnt3(gnt3),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rvalid2(rvalid2), .rvalid3(rvalid3),
        .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check grants now, predict read results, then check registered outputs after the edge.
    task automatic cyc(input logic [3:0] exp_gnt);
        exp_t        e;
        logic        was_rst;
        logic        exp_busy;
        logic [3:0]  exp_rv;
        logic [31:0] obs_rd [4];
        #1;
        chk("gnt", {28'd0, gnt3, gnt2, gnt1, gnt0}, {28'd0, exp_gnt});
        was_rst = rst;
        for (int p = 0; p < 4; p++) begin
            if (exp_gnt[p]) begin
                e.port = p;
                e.data = (we && waddr == raddr[p]) ? wdata : mem_m[raddr[p]];
                sb.push_back(e);
            end
        end
        if (we) mem_m[waddr] = wdata;
        exp_busy = was_rst ? 1'b0 : |(req & ~exp_gnt);
        @(posedge clk);
        #1;
        exp_rv = 4'b0000;
        if (was_rst) begin
            for (int p = 0; p < 4; p++) exp_rdata[p] = 32'd0;
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_rv[e.port] = 1'b1;
            exp_rdata[e.port] = e.data;
        end
        obs_rd[0] = rdata0; obs_rd[1] = rdata1; obs_rd[2] = rdata2; obs_rd[3] = rdata3;
        chk("rvalid", {28'd0, rvalid3, rvalid2, rvalid1, rvalid0}, {28'd0, exp_rv});
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        for (int p = 0; p < 4; p++) chk($sformatf("rdata%0d", p), obs_rd[p], exp_rdata[p]);
    endtask

    initial begin
        for (int a = 0; a < 32; a++) mem_m[a] = 32'd0;
        for (int p = 0; p < 4; p++) begin
            exp_rdata[p] = 32'd0;
            raddr[p] = 5'd0;
        end
        rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'd0; req = 4'b0000;

        // reset, with a request presented during reset that must be ignored
        cyc(4'b0000);
        req = 4'b0001;
        cyc(4'b0000);
        rst = 1'b0; req = 4'b0000;
        cyc(4'b0000);

        // single read after a write
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        cyc(4'b0000);
        we = 1'b0; raddr[2] = 5'd5; req = 4'b0100;
        cyc(4'b0100);
        req = 4'b0000;
        cyc(4'b0000);

        // round-robin fairness from a fresh reset, with a write landing during contention
        rst = 1'b1;
        cyc(4'b0000);
        rst = 1'b0;
        raddr[0] = 5'd5; raddr[1] = 5'd1; raddr[2] = 5'd2; raddr[3] = 5'd3;
        req = 4'b1111; we = 1'b1; waddr = 5'd1; wdata = 32'h0000AAAA;
        for (int k = 0; k < 8; k++) begin
            cyc(4'(1 << (k % 4)));
            we = 1'b0;
        end
        req = 4'b0000;
        cyc(4'b0000);

        // pointer resumes after port 1
        req = 4'b0010;
        cyc(4'b0010);
        req = 4'b1001;
        cyc(4'b1000);
        req = 4'b0001;
        cyc(4'b0001);
        req = 4'b0000;
        cyc(4'b0000);

        // write/read collision with bypass, then a plain re-read
        we = 1'b1; waddr = 5'd9; wdata = 32'h12345678; raddr[1] = 5'd9; req = 4'b0010;
        cyc(4'b0010);
        we = 1'b0;
        cyc(4'b0010);
        req = 4'b0000;
        cyc(4'b0000);

        // reset arriving while a read is in flight
        req = 4'b0001;
        cyc(4'b0001);
        rst = 1'b1; req = 4'b0010;
        cyc(4'b0000);
        rst = 1'b0; req = 4'b0011;
        cyc(4'b0001);
        req = 4'b0010;
        cyc(4'b0010);
        req = 4'b0000;
        cyc(4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
